// File: rtl/fp_n32_pkg.sv
// rtl/fp_n32_pkg.sv - shared constants and operand type for the n32 floating-point units
package fp_n32_pkg;

    localparam int DEF_FRAC_WIDTH = 32;
    localparam int DEF_EXP_WIDTH  = 8;
    localparam int EXP_MAX        = 127;
    localparam int EXP_MIN        = -128;
    localparam int ALIGN_SAT      = 35;
    localparam int SHAMT_WIDTH    = 6;
    localparam logic [DEF_FRAC_WIDTH-1:0] FRAC_ONE = 32'h8000_0000;

    typedef struct packed {
        logic                      sign;
        logic [DEF_EXP_WIDTH-1:0]  exp;
        logic [DEF_FRAC_WIDTH-1:0] frac;
    } fp_operand_t;

endpackage

// File: rtl/fp_align_sticky.sv
// rtl/fp_align_sticky.sv - right shift of a fraction into {frac, G, R, S} with sticky collection
module fp_align_sticky #(
    parameter int IN_WIDTH = 32,
    parameter int SH_WIDTH = 6
) (
    input  logic [IN_WIDTH-1:0] i_frac,
    input  logic [SH_WIDTH-1:0] i_shamt,
    output logic [IN_WIDTH+2:0] o_ext
);

    localparam int EW = IN_WIDTH + 3;

    logic [2*EW-1:0] wide;

    // Shift into a double-width window; everything landing in the low half is lost and feeds S
    always_comb begin
        wide  = {i_frac, 3'b000, {EW{1'b0}}} >> i_shamt;
        o_ext = {wide[2*EW-1:EW+1], wide[EW] | (|wide[EW-1:0])};
    end

endmodule

// File: rtl/fadd_far_n32.sv
// rtl/fadd_far_n32.sv - three-stage far-path floating-point adder with valid/ready handshake
module fadd_far_n32
    import fp_n32_pkg::*;
#(
    parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_sign_a,
    input  logic [EXP_WIDTH-1:0] i_exp_a,
    input  logic [FRAC_WIDTH-1:0] i_frac_a,
    input  logic                 i_sign_b,
    input  logic [EXP_WIDTH-1:0] i_exp_b,
    input  logic [FRAC_WIDTH-1:0] i_frac_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sign_c,
    output logic [EXP_WIDTH-1:0] o_exp_c,
    output logic [FRAC_WIDTH-1:0] o_frac_c,
    output logic                 o_ovf,
    output logic                 o_unf,
    output logic                 o_path_err
);

    localparam int EXT_WIDTH = FRAC_WIDTH + 3;
    localparam int DW        = EXP_WIDTH + 1;
    localparam int XW        = EXP_WIDTH + 2;
    localparam logic [DW-1:0]          SAT_D     = DW'(ALIGN_SAT);
    localparam logic [DW-1:0]          TWO_D     = DW'(2);
    localparam logic [SHAMT_WIDTH-1:0] SHAMT_SAT = SHAMT_WIDTH'(ALIGN_SAT);
    localparam logic signed [XW-1:0]   EXP_MAX_X = XW'(EXP_MAX);
    localparam logic signed [XW-1:0]   EXP_MIN_X = XW'(EXP_MIN);

    typedef struct packed {
        fp_operand_t             l;
        logic [FRAC_WIDTH-1:0]   frac_s;
        logic [SHAMT_WIDTH-1:0]  shamt;
        logic                    eff_sub;
        logic                    path_err;
    } s1_t;

    typedef struct packed {
        logic                    sign;
        logic [EXP_WIDTH-1:0]    exp;
        logic [EXT_WIDTH:0]      mag;
        logic                    eff_sub;
        logic                    path_err;
    } s2_t;

    typedef struct packed {
        logic                    sign;
        logic [EXP_WIDTH-1:0]    exp;
        logic [FRAC_WIDTH-1:0]   frac;
        logic                    ovf;
        logic                    unf;
        logic                    path_err;
    } s3_t;

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic adv1, adv2, adv3, load1;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    s3_t  s3_q, s3_d;

    fp_operand_t            op_a, op_b;
    logic [DW-1:0]          diff, dabs;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   zero_a, zero_b, eff_sub_raw, a_is_l;
    logic [EXT_WIDTH-1:0]   l_ext, aligned;
    logic signed [XW-1:0]   exp_w;
    logic [EXT_WIDTH-1:0]   m;
    logic                   round_up;
    logic [FRAC_WIDTH:0]    rounded;
    logic [FRAC_WIDTH-1:0]  frac_r;

    // Handshake: a stage loads when empty or when its content moves on this cycle
    always_comb begin
        adv3    = v3_q & i_ready;
        adv2    = v2_q & (!v3_q | adv3);
        adv1    = v1_q & (!v2_q | adv2);
        o_ready = !v1_q | adv1;
        load1   = i_valid & o_ready;
        v1_d    = load1 | (v1_q & !adv1);
        v2_d    = adv1 | (v2_q & !adv2);
        v3_d    = adv2 | (v3_q & !adv3);
    end

    // Valid bits are the only reset state; in-flight data is discarded by clearing them
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
        end
    end

    // Stage data registers load only when their stage takes new content
    always_ff @(posedge i_clk) begin
        if (load1) s1_q <= s1_d;
        if (adv1)  s2_q <= s2_d;
        if (adv2)  s3_q <= s3_d;
    end

    // S1: exponent compare, operand swap, shift amount and close-path detection
    always_comb begin
        op_a        = {i_sign_a, i_exp_a, i_frac_a};
        op_b        = {i_sign_b, i_exp_b, i_frac_b};
        diff        = {i_exp_a[EXP_WIDTH-1], i_exp_a} - {i_exp_b[EXP_WIDTH-1], i_exp_b};
        dabs        = diff[DW-1] ? -diff : diff;
        shamt       = (dabs > SAT_D) ? SHAMT_SAT : dabs[SHAMT_WIDTH-1:0];
        a_is_l      = !diff[DW-1];
        zero_a      = (i_frac_a == '0);
        zero_b      = (i_frac_b == '0);
        eff_sub_raw = i_sign_a ^ i_sign_b;
        s1_d          = '0;
        s1_d.path_err = eff_sub_raw && (dabs < TWO_D) && !zero_a && !zero_b;
        // A zero operand becomes a zero "small" so the other one flows through unchanged
        if (zero_a && zero_b) begin
            s1_d.l = '0;
        end else if (zero_b) begin
            s1_d.l = op_a;
        end else if (zero_a) begin
            s1_d.l = op_b;
        end else begin
            s1_d.l       = a_is_l ? op_a : op_b;
            s1_d.frac_s  = a_is_l ? op_b.frac : op_a.frac;
            s1_d.shamt   = shamt;
            s1_d.eff_sub = eff_sub_raw;
        end
    end

    fp_align_sticky #(
        .IN_WIDTH (FRAC_WIDTH),
        .SH_WIDTH (SHAMT_WIDTH)
    ) u_align (
        .i_frac  (s1_q.frac_s),
        .i_shamt (s1_q.shamt),
        .o_ext   (aligned)
    );

    // S2: add or subtract the aligned smaller operand from the extended larger one
    always_comb begin
        l_ext         = {s1_q.l.frac, 3'b000};
        s2_d          = '0;
        s2_d.sign     = s1_q.l.sign;
        s2_d.exp      = s1_q.l.exp;
        s2_d.eff_sub  = s1_q.eff_sub;
        s2_d.path_err = s1_q.path_err;
        if (s1_q.eff_sub) begin
            s2_d.mag = {1'b0, l_ext - aligned};
        end else begin
            s2_d.mag = {1'b0, l_ext} + {1'b0, aligned};
        end
    end

    // S3: one-step normalize, round to nearest even, then range checks and special results
    always_comb begin
        exp_w = {{2{s2_q.exp[EXP_WIDTH-1]}}, s2_q.exp};
        if (!s2_q.eff_sub && s2_q.mag[EXT_WIDTH]) begin
            m     = {s2_q.mag[EXT_WIDTH:2], s2_q.mag[1] | s2_q.mag[0]};
            exp_w = exp_w + XW'(1);
        end else if (s2_q.eff_sub && !s2_q.mag[EXT_WIDTH-1]) begin
            m     = {s2_q.mag[EXT_WIDTH-2:0], 1'b0};
            exp_w = exp_w - XW'(1);
        end else begin
            m     = s2_q.mag[EXT_WIDTH-1:0];
        end
        round_up = m[2] & (m[1] | m[0] | m[3]);
        rounded  = {1'b0, m[EXT_WIDTH-1:3]} + {{FRAC_WIDTH{1'b0}}, round_up};
        if (rounded[FRAC_WIDTH]) begin
            frac_r = FRAC_ONE;
            exp_w  = exp_w + XW'(1);
        end else begin
            frac_r = rounded[FRAC_WIDTH-1:0];
        end
        s3_d      = '0;
        s3_d.sign = s2_q.sign;
        s3_d.exp  = exp_w[EXP_WIDTH-1:0];
        s3_d.frac = frac_r;
        if (s2_q.path_err) begin
            s3_d          = '0;
            s3_d.path_err = 1'b1;
        end else if (exp_w > EXP_MAX_X) begin
            s3_d.exp  = EXP_MAX_X[EXP_WIDTH-1:0];
            s3_d.frac = '1;
            s3_d.ovf  = 1'b1;
        end else if (exp_w < EXP_MIN_X) begin
            s3_d     = '0;
            s3_d.unf = 1'b1;
        end
    end

    // Outputs are forced to zero whenever no result is presented
    always_comb begin
        o_valid    = v3_q;
        o_sign_c   = v3_q & s3_q.sign;
        o_exp_c    = v3_q ? s3_q.exp : '0;
        o_frac_c   = v3_q ? s3_q.frac : '0;
        o_ovf      = v3_q & s3_q.ovf;
        o_unf      = v3_q & s3_q.unf;
        o_path_err = v3_q & s3_q.path_err;
    end

endmodule

// File: tb/tb_fadd_far_n32.sv
// tb/tb_fadd_far_n32.sv - directed self-checking bench for fadd_far_n32
module tb_fadd_far_n32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, o_ready, i_ready, o_valid;
    logic        i_sign_a, i_sign_b, o_sign_c;
    logic [7:0]  i_exp_a, i_exp_b, o_exp_c;
    logic [31:0] i_frac_a, i_frac_b, o_frac_c;
    logic        o_ovf, o_unf, o_path_err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic sa; logic [7:0] ea; logic [31:0] fa;
        logic sb; logic [7:0] eb; logic [31:0] fb;
        logic rs; logic [7:0] re; logic [31:0] rf;
        logic ovf; logic unf; logic perr;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    fadd_far_n32 dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_sign_a   (i_sign_a),
        .i_exp_a    (i_exp_a),
        .i_frac_a   (i_frac_a),
        .i_sign_b   (i_sign_b),
        .i_exp_b    (i_exp_b),
        .i_frac_b   (i_frac_b),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_sign_c   (o_sign_c),
        .o_exp_c    (o_exp_c),
        .o_frac_c   (o_frac_c),
        .o_ovf      (o_ovf),
        .o_unf      (o_unf),
        .o_path_err (o_path_err)
    );

    function automatic vec_t mk(logic sa, logic [7:0] ea, logic [31:0] fa,
                                logic sb, logic [7:0] eb, logic [31:0] fb,
                                logic rs, logic [7:0] re, logic [31:0] rf,
                                logic ovf, logic perr);
        vec_t v;
        v = {sa, ea, fa, sb, eb, fb, rs, re, rf, ovf, 1'b0, perr};
        return v;
    endfunction

    function automatic logic [43:0] exp_of(vec_t v);
        return {v.rs, v.re, v.rf, v.ovf, v.unf, v.perr};
    endfunction

    function automatic logic [43:0] observed();
        return {o_sign_c, o_exp_c, o_frac_c, o_ovf, o_unf, o_path_err};
    endfunction

    task automatic drive(input vec_t v);
        i_sign_a = v.sa; i_exp_a = v.ea; i_frac_a = v.fa;
        i_sign_b = v.sb; i_exp_b = v.eb; i_frac_b = v.fb;
    endtask

    // One operation on an idle pipeline; lat = edges from accept to o_valid, 0 on timeout
    task automatic run_single(input vec_t v, output logic [43:0] got, output int lat);
        @(posedge clk); #1;
        drive(v);
        i_valid = 1'b1;
        lat = 0;
        got = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            i_valid = 1'b0;
            if (o_valid) begin
                lat = c;
                got = observed();
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        drive('0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_valid); else n_pass++;
        n_checks++;
        if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", o_ready); else n_pass++;
        n_checks++;
        if (observed() !== 44'h0) $display("FAIL reset_outputs: got %h expected 0", observed()); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_list(input string name, input int ids[$]);
        logic [43:0] got;
        int lat;
        foreach (ids[i]) begin
            run_single(vecs[ids[i]], got, lat);
            n_checks++;
            if (got !== exp_of(vecs[ids[i]]))
                $display("FAIL %s[%0d] result: got %h expected %h", name, ids[i], got, exp_of(vecs[ids[i]]));
            else n_pass++;
            n_checks++;
            if (lat !== 3) $display("FAIL %s[%0d] latency: got %0d expected 3", name, ids[i], lat);
            else n_pass++;
        end
    endtask

    task automatic test_add();
        test_list("add", '{0, 2, 3, 11});
    endtask

    task automatic test_sub();
        test_list("sub", '{1, 6, 7});
    endtask

    task automatic test_special();
        test_list("special", '{4, 5, 8, 9, 10});
    endtask

    task automatic test_back_to_back();
        int occ = 0, sent = 0, got_n = 0, acc, emit;
        logic exp_ready;
        @(posedge clk); #1;
        for (int k = 0; k < 60 && got_n < 6; k++) begin
            i_ready = !(k >= 4 && k <= 7);
            if (sent < 6) begin
                drive(vecs[sent]);
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            exp_ready = (occ < 3) || i_ready;
            n_checks++;
            if (o_ready !== exp_ready)
                $display("FAIL b2b_ready cycle %0d: got %b expected %b", k, o_ready, exp_ready);
            else n_pass++;
            acc  = int'(i_valid && o_ready);
            emit = int'(o_valid && i_ready);
            if (o_valid && got_n < 6) begin
                n_checks++;
                if (observed() !== exp_of(vecs[got_n]))
                    $display("FAIL b2b_out cycle %0d op %0d: got %h expected %h", k, got_n, observed(), exp_of(vecs[got_n]));
                else n_pass++;
            end
            @(posedge clk); #1;
            sent  += acc;
            got_n += emit;
            occ   += acc - emit;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        n_checks++;
        if (got_n !== 6 || sent !== 6)
            $display("FAIL b2b_count: got %0d results from %0d sent expected 6", got_n, sent);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic [43:0] got;
        int lat;
        logic seen;
        @(posedge clk); #1;
        drive(vecs[0]); i_valid = 1'b1;
        @(posedge clk); #1;
        drive(vecs[1]);
        @(posedge clk); #1;
        i_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (o_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", o_valid); else n_pass++;
        n_checks++;
        if (observed() !== 44'h0) $display("FAIL midrst_outputs: got %h expected 0", observed()); else n_pass++;
        n_checks++;
        if (o_ready !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", o_ready); else n_pass++;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen |= o_valid;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL midrst_stale: got valid %b expected 0", seen); else n_pass++;
        run_single(vecs[2], got, lat);
        n_checks++;
        if (got !== exp_of(vecs[2])) $display("FAIL midrst_fresh result: got %h expected %h", got, exp_of(vecs[2]));
        else n_pass++;
        n_checks++;
        if (lat !== 3) $display("FAIL midrst_fresh latency: got %0d expected 3", lat); else n_pass++;
    endtask

    initial begin
        //             sa  ea     fa            sb  eb     fb            rs  re     rf            ovf  perr
        vecs[0]  = mk(0, 8'h00, 32'h8000_0000, 0, 8'h00, 32'h8000_0000, 0, 8'h01, 32'h8000_0000, 0, 0);
        vecs[1]  = mk(0, 8'h00, 32'h8000_0000, 1, 8'hFE, 32'h8000_0000, 0, 8'hFF, 32'hC000_0000, 0, 0);
        vecs[2]  = mk(0, 8'h00, 32'h8000_0001, 0, 8'hE0, 32'h8000_0000, 0, 8'h00, 32'h8000_0002, 0, 0);
        vecs[3]  = mk(0, 8'h00, 32'h8000_0002, 0, 8'hE0, 32'h8000_0000, 0, 8'h00, 32'h8000_0002, 0, 0);
        vecs[4]  = mk(0, 8'h7F, 32'hFFFF_FFFF, 0, 8'h7F, 32'hFFFF_FFFF, 0, 8'h7F, 32'hFFFF_FFFF, 1, 0);
        vecs[5]  = mk(0, 8'h03, 32'h8000_0000, 1, 8'h02, 32'h8000_0000, 0, 8'h00, 32'h0000_0000, 0, 1);
        vecs[6]  = mk(1, 8'h00, 32'h8000_0000, 0, 8'h05, 32'h8000_0000, 0, 8'h04, 32'hF800_0000, 0, 0);
        vecs[7]  = mk(0, 8'h00, 32'h8000_0000, 1, 8'hD8, 32'h8000_0000, 0, 8'h00, 32'h8000_0000, 0, 0);
        vecs[8]  = mk(1, 8'h05, 32'h0000_0000, 1, 8'hFD, 32'hA000_0000, 1, 8'hFD, 32'hA000_0000, 0, 0);
        vecs[9]  = mk(1, 8'h05, 32'h0000_0000, 0, 8'h03, 32'h0000_0000, 0, 8'h00, 32'h0000_0000, 0, 0);
        vecs[10] = mk(0, 8'h10, 32'h8000_0000, 1, 8'h10, 32'hC000_0000, 0, 8'h00, 32'h0000_0000, 0, 1);
        vecs[11] = mk(0, 8'h01, 32'h8000_0000, 0, 8'h00, 32'h8000_0000, 0, 8'h01, 32'hC000_0000, 0, 0);

        test_reset();
        test_add();
        test_sub();
        test_special();
        test_back_to_back();
        test_reset_midstream();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
